// File: rtl/timer_pkg.sv
// Shared constants for the MMIO cycle timer and the cp0 registers it feeds.
// data_mem steering and the bench decode the same addresses from here.
package timer_pkg;

    localparam logic [31:0] TIMER_CYCLE_ADDR      = 32'hffff001c;
    localparam logic [31:0] TIMER_ACK_ADDR        = 32'hffff006c;
    localparam logic [31:0] RESET_INTERRUPT_CYCLE = 32'hffffffff;

    // cp0 register numbers that consume TimerInterrupt
    localparam logic [4:0] CP0_STATUS_REG = 5'd12;
    localparam logic [4:0] CP0_CAUSE_REG  = 5'd13;
    localparam logic [4:0] CP0_EPC_REG    = 5'd14;

    typedef struct packed {
        logic read;   // load from the cycle address
        logic write;  // store to the cycle address (arms compare)
        logic ack;    // store to the acknowledge address
        logic hit;    // either timer address, regardless of direction
    } timer_dec_t;

endpackage

// File: rtl/timer_counter.sv
// Free-running WIDTH-bit cycle counter; wraps silently modulo 2^WIDTH.
// Latency: count_o updates on every rising edge; no backpressure.
module timer_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign count_d = count_q + WIDTH'(1);
    assign count_o = count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/timer_unit.sv
// Memory-mapped cycle timer raising a level interrupt for cp0 until acknowledged.
// Decode and read mux are combinational; interrupt rises one cycle after the match cycle.
module timer_unit #(
    parameter int unsigned      WIDTH                 = 32,
    parameter logic [WIDTH-1:0] TIMER_CYCLE_ADDR      = WIDTH'(timer_pkg::TIMER_CYCLE_ADDR),
    parameter logic [WIDTH-1:0] TIMER_ACK_ADDR        = WIDTH'(timer_pkg::TIMER_ACK_ADDR),
    parameter logic [WIDTH-1:0] RESET_INTERRUPT_CYCLE = WIDTH'(timer_pkg::RESET_INTERRUPT_CYCLE)
) (
    input  logic             clock,
    input  logic             reset,
    output logic             TimerInterrupt,
    output logic [WIDTH-1:0] cycle,
    output logic             TimerAddress,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] data,
    input  logic             MemRead,
    input  logic             MemWrite
);
    import timer_pkg::*;

    timer_dec_t       dec;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] interrupt_cycle_q;
    logic [WIDTH-1:0] interrupt_cycle_d;
    logic             interrupt_line_q;
    logic             interrupt_line_d;
    logic             match;

    always_comb begin
        dec       = '0;
        dec.read  = MemRead  & (address == TIMER_CYCLE_ADDR);
        dec.write = MemWrite & (address == TIMER_CYCLE_ADDR);
        dec.ack   = MemWrite & (address == TIMER_ACK_ADDR);
        dec.hit   = (address == TIMER_CYCLE_ADDR) | (address == TIMER_ACK_ADDR);
    end

    timer_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk_i   (clock),
        .rst_i   (reset),
        .count_o (count)
    );

    // Compare against the stored value, so a store landing this cycle only takes effect next cycle.
    assign match = (count == interrupt_cycle_q);

    always_comb begin
        interrupt_cycle_d = interrupt_cycle_q;
        if (dec.write) begin
            interrupt_cycle_d = data;
        end

        interrupt_line_d = interrupt_line_q;
        if (dec.ack) begin
            interrupt_line_d = 1'b0;
        end else if (match) begin
            interrupt_line_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            interrupt_cycle_q <= RESET_INTERRUPT_CYCLE;
            interrupt_line_q  <= 1'b0;
        end else begin
            interrupt_cycle_q <= interrupt_cycle_d;
            interrupt_line_q  <= interrupt_line_d;
        end
    end

    assign TimerInterrupt = interrupt_line_q;
    assign TimerAddress   = dec.hit;
    assign cycle          = dec.read ? count : '0;

endmodule

// File: tb/tb_timer_unit.sv
// Bench for timer_unit: vector table, directed multi-cycle sequences, an 8-bit wrap instance
// and a randomized run scored against a cycle-level reference model.
module tb_timer_unit;
    import timer_pkg::*;

    localparam logic [31:0] CA = TIMER_CYCLE_ADDR;
    localparam logic [31:0] AA = TIMER_ACK_ADDR;
    localparam logic [31:0] OA = 32'hffff0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address, data;
    logic        MemRead, MemWrite;
    logic        TimerInterrupt;
    logic [31:0] cycle;
    logic        TimerAddress;

    logic [7:0]  a8, d8, cyc8;
    logic        r8, w8, irq8, ta8;

    always #5 clock = ~clock;

    timer_unit dut (
        .clock          (clock),
        .reset          (reset),
        .TimerInterrupt (TimerInterrupt),
        .cycle          (cycle),
        .TimerAddress   (TimerAddress),
        .address        (address),
        .data           (data),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite)
    );

    timer_unit #(.WIDTH(8)) u8 (
        .clock          (clock),
        .reset          (reset),
        .TimerInterrupt (irq8),
        .cycle          (cyc8),
        .TimerAddress   (ta8),
        .address        (a8),
        .data           (d8),
        .MemRead        (r8),
        .MemWrite       (w8)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: cycles elapsed since reset, armed compare value, pending flag.
    logic [31:0] m_cnt, m_cmp;
    logic        m_irq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        rd;
        logic        wr;
        logic [31:0] e_cyc;
        logic        e_ta;
        logic        e_irq;
    } vec_t;

    vec_t tbl[25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        address  = '0; data = '0; MemRead = 1'b0; MemWrite = 1'b0;
        a8       = '0; d8 = '0; r8 = 1'b0; w8 = 1'b0;
        reset    = 1'b1;
        #2;
        reset    = 1'b0;
        m_cnt    = 32'd0;
        m_cmp    = 32'hffffffff;
        m_irq    = 1'b0;
    endtask

    // One bus cycle on the 32-bit DUT: drive, sample mid-cycle, check against model, advance.
    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr,
                       output logic [31:0] s_cyc, output logic s_ta, output logic s_irq);
        address  = a; data = d; MemRead = rd; MemWrite = wr;
        #1;
        s_cyc = cycle;
        s_ta  = TimerAddress;
        s_irq = TimerInterrupt;
        check("mdl_cycle", s_cyc, (rd && a == CA) ? m_cnt : 32'd0);
        check("mdl_taddr", 32'(s_ta), 32'(a == CA || a == AA));
        check("mdl_irq",   32'(s_irq), 32'(m_irq));
        @(posedge clock);
        if (wr && a == AA)        m_irq = 1'b0;
        else if (m_cnt == m_cmp)  m_irq = 1'b1;
        if (wr && a == CA)        m_cmp = d;
        m_cnt = m_cnt + 32'd1;
        #1;
    endtask

    initial begin
        logic [31:0] sc;
        logic        sta, si;
        logic [31:0] ra, rd_;
        logic        rrd, rwr;
        int          pick;

        //        addr  data  rd  wr  cycle ta irq   (row index == cycle count)
        tbl[0]  = '{CA, 0,    1, 0, 0,  1, 0};
        tbl[1]  = '{CA, 0,    1, 0, 1,  1, 0};
        tbl[2]  = '{CA, 4,    0, 1, 0,  1, 0};
        tbl[3]  = '{AA, 0,    1, 0, 0,  1, 0};
        tbl[4]  = '{0,  0,    0, 0, 0,  0, 0};
        tbl[5]  = '{0,  0,    0, 0, 0,  0, 1};
        tbl[6]  = '{CA, 0,    1, 0, 6,  1, 1};
        tbl[7]  = '{CA, 100,  0, 1, 0,  1, 1};
        tbl[8]  = '{OA, 0,    1, 0, 0,  0, 1};
        tbl[9]  = '{AA, 'h55, 0, 1, 0,  1, 1};
        tbl[10] = '{0,  0,    0, 0, 0,  0, 0};
        tbl[11] = '{CA, 13,   0, 1, 0,  1, 0};
        tbl[12] = '{0,  0,    0, 0, 0,  0, 0};
        tbl[13] = '{AA, 7,    0, 1, 0,  1, 0};
        tbl[14] = '{CA, 18,   0, 1, 0,  1, 0};
        tbl[15] = '{0,  0,    0, 0, 0,  0, 0};
        tbl[16] = '{0,  0,    0, 0, 0,  0, 0};
        tbl[17] = '{0,  0,    0, 0, 0,  0, 0};
        tbl[18] = '{0,  0,    0, 0, 0,  0, 0};
        tbl[19] = '{0,  0,    0, 0, 0,  0, 1};
        tbl[20] = '{AA, 0,    0, 1, 0,  1, 1};
        tbl[21] = '{CA, 21,   0, 1, 0,  1, 0};
        tbl[22] = '{CA, 0,    1, 0, 22, 1, 0};
        tbl[23] = '{0,  0,    0, 0, 0,  0, 0};
        tbl[24] = '{0,  0,    0, 0, 0,  0, 0};

        do_reset();
        for (int i = 0; i < 25; i++) begin
            cyc(tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].wr, sc, sta, si);
            check($sformatf("tbl%0d_cycle", i), sc, tbl[i].e_cyc);
            check($sformatf("tbl%0d_taddr", i), 32'(sta), 32'(tbl[i].e_ta));
            check($sformatf("tbl%0d_irq", i), 32'(si), 32'(tbl[i].e_irq));
        end

        // Ten idle cycles, then a load of the cycle address.
        do_reset();
        for (int k = 0; k < 10; k++) cyc(0, 0, 1'b0, 1'b0, sc, sta, si);
        cyc(CA, 0, 1'b1, 1'b0, sc, sta, si);
        check("A_cycle10", sc, 32'd10);
        check("A_irq", 32'(si), 32'd0);
        check("A_taddr", 32'(sta), 32'd1);

        // Arm 20 at cycle 5; interrupt high from cycle 21 and held.
        do_reset();
        for (int k = 0; k < 72; k++) begin
            cyc((k == 5) ? CA : 32'd0, 32'd20, 1'b0, (k == 5), sc, sta, si);
            check($sformatf("B_irq_c%0d", k), 32'(si), 32'(k >= 21));
        end

        // Asynchronous reset between edges while the interrupt is pending.
        address = CA; MemRead = 1'b1; MemWrite = 1'b0;
        reset   = 1'b1;
        #1;
        check("F_irq_async", 32'(TimerInterrupt), 32'd0);
        check("F_cycle_async", cycle, 32'd0);
        #1;
        reset = 1'b0;
        m_cnt = 32'd0; m_cmp = 32'hffffffff; m_irq = 1'b0;
        for (int k = 0; k < 300; k++) cyc(0, 0, 1'b0, 1'b0, sc, sta, si);
        check("F_no_fire", 32'(si), 32'd0);

        // 8-bit instance: compare 2 armed before the wrap fires only after count 2.
        do_reset();
        for (int k = 0; k < 261; k++) begin
            a8 = (k == 10 || k == 255 || k == 256 || k == 257) ? 8'h1c : 8'h00;
            d8 = 8'h02;
            w8 = (k == 10);
            r8 = (k == 255 || k == 256 || k == 257);
            #1;
            check($sformatf("W_irq_c%0d", k), 32'(irq8), 32'(k >= 259));
            if (k == 10)  check("W_taddr", 32'(ta8), 32'd1);
            if (k == 255) check("W_cycle_ff", 32'(cyc8), 32'hff);
            if (k == 256) check("W_cycle_00", 32'(cyc8), 32'h00);
            if (k == 257) check("W_cycle_01", 32'(cyc8), 32'h01);
            @(posedge clock);
            #1;
        end

        // Randomized traffic with compare values near the running count so matches occur.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            pick = $urandom_range(0, 3);
            case (pick)
                0:       ra = CA;
                1:       ra = AA;
                2:       ra = OA;
                default: ra = $urandom;
            endcase
            rd_ = m_cnt + 32'($urandom_range(0, 6));
            rrd = 1'($urandom_range(0, 1));
            rwr = ($urandom_range(0, 3) == 0);
            cyc(ra, rd_, rrd, rwr, sc, sta, si);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
